// File: rtl/chk_pkg.sv
// Shared types and defaults for the response checker and its companion stimulus generator.
package chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_IN_W    = 2;
    localparam int DEF_OUT_W   = 1;
    localparam int DEF_TABLE_W = (2 ** DEF_IN_W) * DEF_OUT_W;

    // Default truth table is a 2-input AND: only entry 3 is high.
    localparam logic [DEF_TABLE_W-1:0] DEF_EXP_TABLE = 4'b1000;

endpackage

// File: rtl/exp_lut.sv
// Combinational truth-table lookup: in_vec selects an OUT_W-wide slice of EXP_TABLE.
module exp_lut
    import chk_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter logic [(2**IN_W)*OUT_W-1:0] EXP_TABLE = DEF_EXP_TABLE
) (
    input  logic [IN_W-1:0]  in_vec,
    output logic [OUT_W-1:0] expected
);

    localparam int DEPTH = 2 ** IN_W;

    logic [OUT_W-1:0] entry [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry[gi] = EXP_TABLE[gi*OUT_W +: OUT_W];
        end
    endgenerate

    assign expected = entry[in_vec];

endmodule

// File: rtl/resp_checker.sv
// Response checker: compares observed DUT outputs against a parameter truth table,
// counting vectors and mismatches and capturing the first mismatch of each run.
module resp_checker
    import chk_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter logic [(2**IN_W)*OUT_W-1:0] EXP_TABLE = DEF_EXP_TABLE,
    parameter int NUM_VEC = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_vec,
    input  logic [OUT_W-1:0] in_obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [IN_W-1:0]  first_err_vec,
    output logic [OUT_W-1:0] first_err_obs
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] vec_cnt_reg, vec_cnt_next;
    logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
    logic             fe_valid_reg, fe_valid_next;
    logic [IN_W-1:0]  fe_vec_reg, fe_vec_next;
    logic [OUT_W-1:0] fe_obs_reg, fe_obs_next;

    logic [OUT_W-1:0] expected;
    logic             accept;
    logic             mismatch;
    logic             last_vec;

    exp_lut #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .EXP_TABLE(EXP_TABLE)
    ) u_exp_lut (
        .in_vec  (in_vec),
        .expected(expected)
    );

    assign accept   = in_valid & in_ready;
    assign mismatch = (in_obs != expected);
    assign last_vec = (vec_cnt_reg == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a start pulse always (re)enters RUN
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (start)                   state_next = RUN;
                else if (accept && last_vec) state_next = DONE;
            end
            DONE: begin
                if (start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from registered state only (in_ready also masks start)
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        pass     = 1'b0;
        case (state_reg)
            RUN: begin
                busy     = 1'b1;
                in_ready = ~start;
            end
            DONE: begin
                done = 1'b1;
                pass = (err_cnt_reg == '0);
            end
            default: ;
        endcase
    end

    // Statistics update: start wins over any concurrent pair
    always_comb begin
        vec_cnt_next  = vec_cnt_reg;
        err_cnt_next  = err_cnt_reg;
        fe_valid_next = fe_valid_reg;
        fe_vec_next   = fe_vec_reg;
        fe_obs_next   = fe_obs_reg;
        if (start) begin
            vec_cnt_next  = '0;
            err_cnt_next  = '0;
            fe_valid_next = 1'b0;
            fe_vec_next   = '0;
            fe_obs_next   = '0;
        end else if (accept) begin
            if (vec_cnt_reg != CNT_MAX) vec_cnt_next = vec_cnt_reg + 1'b1;
            if (mismatch) begin
                if (err_cnt_reg != CNT_MAX) err_cnt_next = err_cnt_reg + 1'b1;
                if (!fe_valid_reg) begin
                    fe_valid_next = 1'b1;
                    fe_vec_next   = in_vec;
                    fe_obs_next   = in_obs;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt_reg  <= '0;
            err_cnt_reg  <= '0;
            fe_valid_reg <= 1'b0;
            fe_vec_reg   <= '0;
            fe_obs_reg   <= '0;
        end else begin
            vec_cnt_reg  <= vec_cnt_next;
            err_cnt_reg  <= err_cnt_next;
            fe_valid_reg <= fe_valid_next;
            fe_vec_reg   <= fe_vec_next;
            fe_obs_reg   <= fe_obs_next;
        end
    end

    assign vec_cnt         = vec_cnt_reg;
    assign err_cnt         = err_cnt_reg;
    assign first_err_valid = fe_valid_reg;
    assign first_err_vec   = fe_vec_reg;
    assign first_err_obs   = fe_obs_reg;

endmodule

// File: tb/tb_resp_checker.sv
// Directed bench for resp_checker with a run-level behavioural model checked every cycle.
module tb_resp_checker;

    localparam int IN_W    = 2;
    localparam int OUT_W   = 1;
    localparam int NUM_VEC = 4;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_vec = '0;
    logic [OUT_W-1:0] in_obs = '0;
    logic             busy, done, pass;
    logic [CNT_W-1:0] vec_cnt, err_cnt;
    logic             first_err_valid;
    logic [IN_W-1:0]  first_err_vec;
    logic [OUT_W-1:0] first_err_obs;

    int errors = 0;
    int checks = 0;

    // Model: the pairs accepted in the current run, and whether a run is active/finished
    logic [IN_W+OUT_W-1:0] m_q[$];
    int                    m_mode = 0;   // 0 = no run yet, 1 = running, 2 = finished

    resp_checker #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .EXP_TABLE(4'b1000),
        .NUM_VEC  (NUM_VEC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_vec         (in_vec),
        .in_obs         (in_obs),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .vec_cnt        (vec_cnt),
        .err_cnt        (err_cnt),
        .first_err_valid(first_err_valid),
        .first_err_vec  (first_err_vec),
        .first_err_obs  (first_err_obs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Intended function of the default table: output is the AND of the input bits
    function automatic logic golden(input logic [IN_W-1:0] v);
        return &v;
    endfunction

    task automatic compare_loop();
        int          n_err;
        logic        f_valid;
        logic [IN_W-1:0]  f_vec;
        logic [OUT_W-1:0] f_obs;
        logic [IN_W-1:0]  v;
        logic [OUT_W-1:0] o;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_mode = 0;
            end else if (start) begin
                m_q.delete();
                m_mode = 1;
            end else if (m_mode == 1 && in_valid) begin
                m_q.push_back({in_vec, in_obs});
                if (m_q.size() == NUM_VEC) m_mode = 2;
            end
            #1;
            n_err = 0; f_valid = 1'b0; f_vec = '0; f_obs = '0;
            foreach (m_q[k]) begin
                {v, o} = m_q[k];
                if (o != OUT_W'(golden(v))) begin
                    n_err++;
                    if (!f_valid) begin
                        f_valid = 1'b1; f_vec = v; f_obs = o;
                    end
                end
            end
            chk("in_ready", in_ready, (rst_n && m_mode == 1 && !start) ? 1 : 0);
            chk("busy", busy, (m_mode == 1) ? 1 : 0);
            chk("done", done, (m_mode == 2) ? 1 : 0);
            chk("pass", pass, (m_mode == 2 && n_err == 0) ? 1 : 0);
            chk("vec_cnt", vec_cnt, m_q.size());
            chk("err_cnt", err_cnt, n_err);
            chk("first_err_valid", first_err_valid, f_valid);
            chk("first_err_vec", first_err_vec, f_vec);
            chk("first_err_obs", first_err_obs, f_obs);
        end
    endtask

    task automatic pulse_start(input logic with_valid);
        @(negedge clk);
        start    = 1'b1;
        in_valid = with_valid;
        in_vec   = '0;
        in_obs   = '0;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Offer one pair after `gap` idle cycles and hold it until accepted (bounded)
    task automatic send(input logic [IN_W-1:0] v, input logic [OUT_W-1:0] o, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_vec   = v;
        in_obs   = o;
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1);
        @(posedge clk);
        $display("send vec=%0d obs=%0d waits=%0d t=%0t", v, o, n, $time);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        fork
            compare_loop();
        join_none

        // Reset held, then idle: in_valid alone must not be accepted
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_busy", busy, 0);
        idle(1);

        // Clean run; the pair offered with start is not counted
        pulse_start(1'b1);
        send(2'b00, 1'b0, 0);
        send(2'b01, 1'b0, 0);
        send(2'b10, 1'b0, 0);
        send(2'b11, 1'b1, 0);
        @(negedge clk);
        in_vec = 2'b00; in_obs = 1'b0;
        #1;
        chk("lit_ready_after_last", in_ready, 0);
        chk("lit_clean_vec_cnt", vec_cnt, 4);
        chk("lit_clean_err_cnt", err_cnt, 0);
        chk("lit_clean_done", done, 1);
        chk("lit_clean_pass", pass, 1);
        chk("lit_clean_busy", busy, 0);
        chk("lit_clean_fev", first_err_valid, 0);
        idle(2);

        // Two mismatches: capture must hold the first one
        pulse_start(1'b0);
        send(2'b00, 1'b0, 0);
        send(2'b01, 1'b1, 0);
        send(2'b10, 1'b1, 0);
        send(2'b11, 1'b1, 0);
        idle(1);
        chk("lit_err_err_cnt", err_cnt, 2);
        chk("lit_err_pass", pass, 0);
        chk("lit_err_done", done, 1);
        chk("lit_err_fev", first_err_valid, 1);
        chk("lit_err_vec", first_err_vec, 1);
        chk("lit_err_obs", first_err_obs, 1);

        // Gaps between offers, including a wrong 11 -> 0
        pulse_start(1'b0);
        send(2'b11, 1'b0, 2);
        send(2'b10, 1'b0, 1);
        send(2'b00, 1'b0, 3);
        idle(2);
        chk("lit_gap_vec_cnt", vec_cnt, 3);
        chk("lit_gap_busy", busy, 1);
        send(2'b01, 1'b0, 0);
        idle(1);
        chk("lit_gap_err_cnt", err_cnt, 1);
        chk("lit_gap_fe_vec", first_err_vec, 3);
        chk("lit_gap_fe_obs", first_err_obs, 0);

        // Restart mid-run after one good and one bad vector
        pulse_start(1'b0);
        send(2'b00, 1'b0, 0);
        send(2'b10, 1'b1, 0);
        pulse_start(1'b1);
        chk("lit_restart_vec_cnt", vec_cnt, 0);
        chk("lit_restart_fev", first_err_valid, 0);
        send(2'b11, 1'b1, 0);
        send(2'b01, 1'b0, 0);
        send(2'b00, 1'b0, 0);
        send(2'b10, 1'b0, 0);
        idle(1);
        chk("lit_restart_pass", pass, 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lit_redone_done", done, 0);
        chk("lit_redone_busy", busy, 1);

        // Asynchronous reset mid-run after three accepts
        send(2'b01, 1'b1, 0);
        send(2'b11, 1'b1, 0);
        send(2'b00, 1'b0, 0);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_rst_vec_cnt", vec_cnt, 0);
        chk("lit_rst_err_cnt", err_cnt, 0);
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_fev", first_err_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("lit_post_rst_ready", in_ready, 0);
        chk("lit_post_rst_vec_cnt", vec_cnt, 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
